// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants for the register file / issue scoreboard slice.
package regfile_scoreboard_pkg;

  // Bank selectors (upper address field).
  localparam int BANK_GPR = 0;
  localparam int BANK_FPR = 1;

  // Hardwired-zero register lives at bank GPR, index ZERO_IDX.
  localparam int ZERO_IDX = 0;

  // Registers with non-zero reset contents (bank GPR).
  localparam int R28_IDX = 28;
  localparam int R29_IDX = 29;

  localparam logic [31:0] INIT28_DEF = 32'h000F4240;
  localparam logic [31:0] INIT29_DEF = 32'h00000030;

endpackage

// File: rtl/regfile_scoreboard_sb.sv
// Issue scoreboard: per-register pending bits, write-back latency countdowns,
// sticky error flag and the combinational issue stall.
module reg_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int NBANK = 2,
  parameter int NREAD = 2,
  parameter int WAITW = 5,
  parameter int SLACK = 4,
  localparam int AW   = $clog2(NBANK) + $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NREAD-1:0]    rd_en,
  input  logic [NREAD*AW-1:0] rd_addr,
  input  logic                iss_valid,
  input  logic                iss_we,
  input  logic [AW-1:0]       iss_dst,
  input  logic [WAITW-1:0]    iss_wait,
  input  logic                wb_valid,
  input  logic [AW-1:0]       wb_addr,
  output logic                stall,
  output logic                err
);

  localparam int NENT = 1 << AW;
  localparam int CW   = WAITW + 1;
  localparam logic [AW-1:0] ZERO_ADDR = AW'(BANK_GPR * NREG + ZERO_IDX);

  logic [NENT-1:0] pend_q, pend_d;
  logic [CW-1:0]   cnt_q [NENT];
  logic [CW-1:0]   cnt_d [NENT];
  logic            err_q, err_d;
  logic            src_block;
  logic            wb_hit;
  logic            issue_acc;
  logic [CW-1:0]   load_val;

  // Zero-extended so the declared latency plus slack never wraps.
  assign load_val  = {1'b0, iss_wait} + CW'(SLACK);
  assign wb_hit    = wb_valid && (wb_addr != ZERO_ADDR);
  assign issue_acc = iss_valid && iss_we && !stall && (iss_dst != ZERO_ADDR);
  assign err       = err_q;

  // Stall on RAW (unless the source is written back this cycle) or on WAW.
  always_comb begin
    src_block = 1'b0;
    for (int p = 0; p < NREAD; p++) begin
      if (rd_en[p] && pend_q[rd_addr[p*AW +: AW]] &&
          !(wb_valid && (wb_addr == rd_addr[p*AW +: AW])))
        src_block = 1'b1;
    end
    stall = iss_valid && (src_block || (iss_we && pend_q[iss_dst]));
  end

  // Next state: countdowns and timeouts first, then write-back clear, then
  // issue set, so a same-cycle issue to the written-back register wins.
  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    for (int i = 0; i < NENT; i++) begin
      if (pend_q[i]) begin
        cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CW'(1) : '0;
        if (!(wb_hit && (wb_addr == AW'(i))) && (cnt_q[i] <= CW'(1)))
          err_d = 1'b1;
      end
    end
    if (wb_hit) begin
      if (!pend_q[wb_addr])
        err_d = 1'b1;
      pend_d[wb_addr] = 1'b0;
    end
    if (issue_acc) begin
      pend_d[iss_dst] = 1'b1;
      cnt_d[iss_dst]  = load_val;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pend_q <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < NENT; i++)
        cnt_q[i] <= '0;
    end else begin
      pend_q <= pend_d;
      err_q  <= err_d;
      for (int i = 0; i < NENT; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Banked register file with registered, write-back-forwarding read ports and
// an integrated issue scoreboard.
//
// Issue handshake: an instruction is presented with iss_valid; it is accepted
// on a rising edge where iss_valid is high and stall is low. stall never
// depends on acceptance, and inputs must hold while stalled.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int NBANK = 2,
  parameter int NREAD = 2,
  parameter int WAITW = 5,
  parameter int SLACK = 4,
  parameter logic [XLEN-1:0] INIT28 = XLEN'(INIT28_DEF),
  parameter logic [XLEN-1:0] INIT29 = XLEN'(INIT29_DEF),
  localparam int AW = $clog2(NBANK) + $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREAD-1:0]      rd_en,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  input  logic                  iss_valid,
  input  logic                  iss_we,
  input  logic [AW-1:0]         iss_dst,
  input  logic [WAITW-1:0]      iss_wait,
  output logic                  stall,
  input  logic                  wb_valid,
  input  logic [AW-1:0]         wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  output logic [XLEN-1:0]       dbg_r29,
  output logic                  err
);

  localparam int NENT = 1 << AW;
  localparam logic [AW-1:0] ZERO_ADDR = AW'(BANK_GPR * NREG + ZERO_IDX);
  localparam logic [AW-1:0] R28_ADDR  = AW'(BANK_GPR * NREG + R28_IDX);
  localparam logic [AW-1:0] R29_ADDR  = AW'(BANK_GPR * NREG + R29_IDX);

  logic [XLEN-1:0] mem_q [NENT];
  logic [XLEN-1:0] rd_q  [NREAD];
  logic [XLEN-1:0] rd_d  [NREAD];
  logic            wb_hit;

  assign wb_hit  = wb_valid && (wb_addr != ZERO_ADDR);
  assign dbg_r29 = mem_q[R29_ADDR];

  // Register array: reset image, then write-back (zero register never written).
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NENT; i++) begin
        if (AW'(i) == R28_ADDR)      mem_q[i] <= INIT28;
        else if (AW'(i) == R29_ADDR) mem_q[i] <= INIT29;
        else                         mem_q[i] <= '0;
      end
    end else if (wb_hit) begin
      mem_q[wb_addr] <= wb_data;
    end
  end

  // Read mux: forward same-cycle write-back data, otherwise read the array.
  always_comb begin
    for (int p = 0; p < NREAD; p++) begin
      rd_d[p] = mem_q[rd_addr[p*AW +: AW]];
      if (wb_hit && (wb_addr == rd_addr[p*AW +: AW]))
        rd_d[p] = wb_data;
    end
  end

  // Registered read data.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int p = 0; p < NREAD; p++)
        rd_q[p] <= '0;
    end else begin
      for (int p = 0; p < NREAD; p++)
        rd_q[p] <= rd_d[p];
    end
  end

  // Flatten read ports onto the output bus.
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NREAD; p++)
      rd_data[p*XLEN +: XLEN] = rd_q[p];
  end

  reg_scoreboard #(
    .NREG  (NREG),
    .NBANK (NBANK),
    .NREAD (NREAD),
    .WAITW (WAITW),
    .SLACK (SLACK)
  ) u_sb (
    .clk       (clk),
    .rstn      (rstn),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .iss_valid (iss_valid),
    .iss_we    (iss_we),
    .iss_dst   (iss_dst),
    .iss_wait  (iss_wait),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .stall     (stall),
    .err       (err)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard (NBANK=4, NREAD=3 build).
module tb_regfile_scoreboard;
  import regfile_scoreboard_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int NBANK = 4;
  localparam int NREAD = 3;
  localparam int WAITW = 5;
  localparam int SLACK = 4;
  localparam int AW    = 7;
  localparam int NENT  = 128;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [NREAD-1:0]      rd_en;
  logic [AW-1:0]         rd_a [NREAD];
  logic [NREAD*AW-1:0]   rd_addr;
  wire  [NREAD*XLEN-1:0] rd_data;
  logic                  iss_valid, iss_we;
  logic [AW-1:0]         iss_dst;
  logic [WAITW-1:0]      iss_wait;
  wire                   stall;
  logic                  wb_valid;
  logic [AW-1:0]         wb_addr;
  logic [XLEN-1:0]       wb_data;
  wire  [XLEN-1:0]       dbg_r29;
  wire                   err;

  assign rd_addr = {rd_a[2], rd_a[1], rd_a[0]};

  regfile_scoreboard #(
    .XLEN(XLEN), .NREG(NREG), .NBANK(NBANK), .NREAD(NREAD),
    .WAITW(WAITW), .SLACK(SLACK)
  ) u_dut (
    .clk(clk), .rstn(rstn), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .iss_valid(iss_valid), .iss_we(iss_we), .iss_dst(iss_dst), .iss_wait(iss_wait),
    .stall(stall), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .dbg_r29(dbg_r29), .err(err)
  );

  int checks = 0;
  int errors = 0;
  int n_edge = 0;

  // ---------------- reference model ----------------
  // Architectural view: register contents, which registers await a write-back
  // and the absolute edge number by which that write-back is due.
  logic [XLEN-1:0] m_mem [NENT];
  bit              m_pend [NENT];
  int              m_deadline [NENT];
  bit              m_err;
  logic [XLEN-1:0] m_rd [NREAD];
  logic [XLEN-1:0] exp_q [$];

  function automatic logic [XLEN-1:0] rdp(int p);
    return rd_data[p*XLEN +: XLEN];
  endfunction

  function automatic bit model_stall();
    bit s = 0;
    for (int p = 0; p < NREAD; p++)
      if (rd_en[p] && m_pend[rd_a[p]] && !(wb_valid && wb_addr == rd_a[p])) s = 1;
    if (iss_we && m_pend[iss_dst]) s = 1;
    return iss_valid && s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) begin
      m_mem[i] = '0;
      m_pend[i] = 0;
      m_deadline[i] = 0;
    end
    m_mem[28] = INIT28_DEF;
    m_mem[29] = INIT29_DEF;
    m_err = 0;
    for (int p = 0; p < NREAD; p++) m_rd[p] = '0;
  endtask

  // Apply the current inputs to the model, then advance one clock edge.
  task automatic tick();
    bit s;
    n_edge++;
    if (!rstn) begin
      model_reset();
    end else begin
      s = model_stall();
      for (int p = 0; p < NREAD; p++)
        m_rd[p] = (wb_valid && wb_addr != 0 && wb_addr == rd_a[p]) ? wb_data : m_mem[rd_a[p]];
      for (int i = 0; i < NENT; i++)
        if (m_pend[i] && !(wb_valid && wb_addr == AW'(i)) && n_edge >= m_deadline[i]) m_err = 1;
      if (wb_valid && wb_addr != 0) begin
        if (!m_pend[wb_addr]) m_err = 1;
        m_pend[wb_addr] = 0;
        m_mem[wb_addr] = wb_data;
      end
      if (iss_valid && iss_we && !s && iss_dst != 0) begin
        m_pend[iss_dst] = 1;
        m_deadline[iss_dst] = n_edge + int'(iss_wait) + SLACK;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    rd_en = '0;
    for (int p = 0; p < NREAD; p++) rd_a[p] = '0;
    iss_valid = 0; iss_we = 0; iss_dst = '0; iss_wait = '0;
    wb_valid = 0; wb_addr = '0; wb_data = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rstn = 0;
    tick();
    tick();
    rstn = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (dbg_r29 !== 32'h00000030) begin errors++; $display("FAIL reset_dbg_r29: got %h expected 00000030", dbg_r29); end
    rd_a[0] = 7'd28; rd_a[1] = 7'd29; rd_a[2] = 7'd67; rd_en = 3'b111;
    iss_valid = 1; iss_we = 1; iss_dst = 7'd9; iss_wait = 5'd3;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    tick();
    checks++; if (rdp(0) !== 32'h000F4240) begin errors++; $display("FAIL reset_r28: got %h expected 000F4240", rdp(0)); end
    checks++; if (rdp(1) !== 32'h00000030) begin errors++; $display("FAIL reset_r29: got %h expected 00000030", rdp(1)); end
    checks++; if (rdp(2) !== 32'h0) begin errors++; $display("FAIL reset_other: got %h expected 0", rdp(2)); end
    drive_idle();
  endtask

  task automatic test_raw();
    do_reset();
    iss_valid = 1; iss_we = 1; iss_dst = 7'd5; iss_wait = 5'd3;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_first_issue: got %b expected 0", stall); end
    tick();
    iss_we = 0; rd_en = 3'b001; rd_a[0] = 7'd5;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall cyc%0d: got %b expected 1", k, stall); end
      tick();
    end
    wb_valid = 1; wb_addr = 7'd5; wb_data = 32'hDEADBEEF;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_release: got %b expected 0", stall); end
    tick();
    checks++; if (rdp(0) !== 32'hDEADBEEF) begin errors++; $display("FAIL raw_forward: got %h expected DEADBEEF", rdp(0)); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL raw_err: got %b expected 0", err); end
    drive_idle(); rd_a[0] = 7'd5;
    tick();
    checks++; if (rdp(0) !== 32'hDEADBEEF) begin errors++; $display("FAIL raw_array: got %h expected DEADBEEF", rdp(0)); end
    drive_idle();
  endtask

  task automatic test_waw();
    do_reset();
    iss_valid = 1; iss_we = 1; iss_dst = 7'd39; iss_wait = 5'd5;
    tick();
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_stall: got %b expected 1", stall); end
    tick();
    wb_valid = 1; wb_addr = 7'd39; wb_data = 32'h1111_2222;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_stall_on_wb: got %b expected 1", stall); end
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL waw_err_clean: got %b expected 0", err); end
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL waw_issue_with_wb: got %b expected 0", stall); end
    tick();
    wb_valid = 0;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_still_pending: got %b expected 1", stall); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL waw_unexpected_wb_err: got %b expected 1", err); end
    drive_idle();
  endtask

  task automatic test_zero();
    do_reset();
    wb_valid = 1; wb_addr = 7'd0; wb_data = 32'h1234;
    rd_en = 3'b001; rd_a[0] = 7'd0;
    iss_valid = 1; iss_we = 1; iss_dst = 7'd0; iss_wait = 5'd1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall_a: got %b expected 0", stall); end
    tick();
    checks++; if (rdp(0) !== 32'h0) begin errors++; $display("FAIL zero_forward: got %h expected 0", rdp(0)); end
    wb_valid = 0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall_b: got %b expected 0", stall); end
    tick();
    checks++; if (rdp(0) !== 32'h0) begin errors++; $display("FAIL zero_array: got %h expected 0", rdp(0)); end
    drive_idle();
  endtask

  task automatic test_timeout();
    do_reset();
    iss_valid = 1; iss_we = 1; iss_dst = 7'd10; iss_wait = 5'd2;
    tick();
    drive_idle();
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (err !== ((k >= 2 + SLACK) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL timeout_err k=%0d: got %b expected %b", k, err, (k >= 2 + SLACK));
      end
    end
    do_reset();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL timeout_reset_clears: got %b expected 0", err); end
    wb_valid = 1; wb_addr = 7'd12; wb_data = 32'h55;
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL idle_wb_err: got %b expected 1", err); end
    drive_idle();
  endtask

  task automatic test_params();
    logic [XLEN-1:0] v;
    do_reset();
    exp_q.delete();
    for (int b = 0; b < NBANK; b++) begin
      v = 32'hA000_0000 + 32'(b * 32'h0101);
      exp_q.push_back(v);
      wb_valid = 1; wb_addr = AW'(b * NREG + 3); wb_data = v;
      tick();
    end
    // banks 0,1 from the array, bank 3 forwarded from a same-cycle write-back
    wb_valid = 1; wb_addr = AW'(3 * NREG + 3); wb_data = 32'hF0F0_0303;
    rd_a[0] = AW'(0 * NREG + 3); rd_a[1] = AW'(1 * NREG + 3); rd_a[2] = AW'(3 * NREG + 3);
    tick();
    checks++; if (rdp(0) !== exp_q[0]) begin errors++; $display("FAIL params_b0: got %h expected %h", rdp(0), exp_q[0]); end
    checks++; if (rdp(1) !== exp_q[1]) begin errors++; $display("FAIL params_b1: got %h expected %h", rdp(1), exp_q[1]); end
    checks++; if (rdp(2) !== 32'hF0F0_0303) begin errors++; $display("FAIL params_b3_fwd: got %h expected F0F00303", rdp(2)); end
    wb_valid = 0;
    rd_a[0] = AW'(2 * NREG + 3); rd_a[1] = AW'(3 * NREG + 3); rd_a[2] = AW'(1 * NREG + 3);
    tick();
    checks++; if (rdp(0) !== exp_q[2]) begin errors++; $display("FAIL params_b2: got %h expected %h", rdp(0), exp_q[2]); end
    checks++; if (rdp(1) !== 32'hF0F0_0303) begin errors++; $display("FAIL params_b3: got %h expected F0F00303", rdp(1)); end
    checks++; if (rdp(2) !== exp_q[1]) begin errors++; $display("FAIL params_b1b: got %h expected %h", rdp(2), exp_q[1]); end
    drive_idle();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int idx;
    idx = ($urandom_range(0, 9) == 0) ? 29 : int'($urandom_range(0, 5));
    return AW'(int'($urandom_range(0, NBANK - 1)) * NREG + idx);
  endfunction

  task automatic test_random();
    int pq [$];
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rstn = ($urandom_range(0, 150) != 0);
      iss_valid = $urandom_range(0, 1);
      iss_we = $urandom_range(0, 1);
      iss_dst = rand_addr();
      iss_wait = 5'($urandom_range(0, 7));
      rd_en = 3'($urandom_range(0, 7));
      for (int p = 0; p < NREAD; p++) rd_a[p] = rand_addr();
      pq.delete();
      for (int i = 0; i < NENT; i++) if (m_pend[i]) pq.push_back(i);
      wb_valid = ($urandom_range(0, 2) != 0);
      if (pq.size() > 0 && $urandom_range(0, 9) != 0)
        wb_addr = AW'(pq[$urandom_range(0, pq.size() - 1)]);
      else
        wb_addr = rand_addr();
      wb_data = $urandom;
      #1;
      if (rstn) begin
        checks++;
        if (stall !== model_stall()) begin errors++; $display("FAIL rand_stall c=%0d: got %b expected %b", c, stall, model_stall()); end
      end
      tick();
      for (int p = 0; p < NREAD; p++) begin
        checks++;
        if (rdp(p) !== m_rd[p]) begin errors++; $display("FAIL rand_rd%0d c=%0d: got %h expected %h", p, c, rdp(p), m_rd[p]); end
      end
      checks++; if (err !== m_err) begin errors++; $display("FAIL rand_err c=%0d: got %b expected %b", c, err, m_err); end
      checks++; if (dbg_r29 !== m_mem[29]) begin errors++; $display("FAIL rand_dbg_r29 c=%0d: got %h expected %h", c, dbg_r29, m_mem[29]); end
    end
    rstn = 1;
    drive_idle();
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    drive_idle();
    model_reset();
    test_reset();
    test_raw();
    test_waw();
    test_zero();
    test_timeout();
    test_params();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
